battleship_turn_ctrl: RTL and testbench
=======================================

Name: battleship_turn_ctrl

Overview:
Top-level game sequencer for the 5x5 battleship board.
- Runs two placement phases: the player's ship-placement unit first, then the PC's.
- Then alternates player and PC shots, with a per-turn countdown that auto-fires on timeout.
- Tracks the remaining ship cells on each side and declares win or lose.
- Sits between the button/switch front end and the placement, attack and display blocks.

Parameters:
CYCLES_PER_SEC, 50_000_000, clk cycles per countdown tick (set to 4 in simulation).
TURN_SECS, 15, player turn length in ticks, range 1..31.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins or restarts a game
ship_q  in  3  ships per side, sampled on accepted start
confirm  in  1  debounced one-cycle pulse from the player's fire button
place_done_p  in  1  level; player placement unit has placed all ships
place_done_pc  in  1  level; PC placement unit has placed all ships
shot_done  in  1  one-cycle pulse; player shot resolved by the attack unit
shot_hit  in  1  qualified by shot_done; player hit a PC ship cell
pc_shot_done  in  1  one-cycle pulse; PC shot resolved
pc_shot_hit  in  1  qualified by pc_shot_done; PC hit a player ship cell
place_en_p  out  1  level enable to the player placement unit
place_en_pc  out  1  level enable to the PC placement unit
fire_p  out  1  one-cycle strobe: fire at the player's cursor
auto_fire  out  1  asserted with fire_p when the shot came from a timeout
fire_pc  out  1  one-cycle strobe: PC takes its shot
secs_left  out  5  countdown shown on the display; 0 outside P_TURN
state  out  3  current state encoding, for the display mux
win  out  1  player sank every PC ship
lose  out  1  PC sank every player ship

Behaviour:
- All outputs are registered. Reset (async) sets state=IDLE and every output to 0.
- States: IDLE=0, PLACE_P=1, PLACE_PC=2, P_TURN=3, P_WAIT=4, PC_TURN=5, PC_WAIT=6, END=7.
- start is accepted only in IDLE or END. Elsewhere it is ignored.
- On an accepted start:
  - ship_q is clamped: 0 becomes 1, values above 5 become 5.
  - Both cells-left counters (4-bit) load n(n+1)/2, giving 1/3/6/10/15.
  - win and lose clear.
  - Next state is PLACE_P.
- PLACE_P: place_en_p=1. When place_done_p=1, go to PLACE_PC and drop place_en_p.
- PLACE_PC: place_en_pc=1. When place_done_pc=1, go to P_TURN.
- Entering P_TURN:
  - secs_left loads TURN_SECS.
  - The prescaler clears.
- Prescaler behaviour in P_TURN:
  - The prescaler counts 0..CYCLES_PER_SEC-1, then wraps.
  - Each wrap is a tick, and a tick decrements secs_left.
- P_TURN exits:
  - On confirm: fire_p=1 for one cycle, auto_fire=0, go to P_WAIT.
  - On a tick with secs_left==1: secs_left becomes 0, fire_p=1 and auto_fire=1 for one cycle, go to P_WAIT.
  - The turn therefore lasts exactly TURN_SECS*CYCLES_PER_SEC cycles.
  - If confirm and the timeout tick arrive in the same cycle, one shot is fired with auto_fire=0.
- P_WAIT:
  - The timer is frozen; secs_left reads 0.
  - confirm is ignored.
  - On shot_done with shot_hit=1, pc_left decrements.
  - If pc_left reaches 0, win=1 and go to END; otherwise go to PC_TURN.
  - On shot_done with shot_hit=0, go to PC_TURN.
- PC_TURN: fire_pc=1 for exactly one cycle, then go to PC_WAIT.
- PC_WAIT:
  - On pc_shot_done, p_left decrements if pc_shot_hit=1.
  - If p_left reaches 0, lose=1 and go to END; otherwise go to P_TURN (timer reloaded).
- Counters never go below 0: a hit reported while a counter is already 0 is ignored.
- Done pulses arriving in any other state are ignored.
- END: win or lose holds until the next accepted start or reset. win and lose are never both 1.
- Reset mid-game is immediate: all strobes and enables drop in the same cycle; there is no drain.

Test Plan:
- Flow with ship_q=2 (CYCLES_PER_SEC=4, TURN_SECS=3):
  - start, place_done_p, then place_done_pc → state goes 1, 2, 3; place enables are exclusive and one-hot.
  - 3 player shots each answered shot_done+shot_hit → win=1, state=7, with fire_pc pulsed exactly 2 times.
- Timeout: sit in P_TURN with no confirm → secs_left steps 3, 2, 1, 0 at 4-cycle intervals; at cycle 12, fire_p=1 and auto_fire=1 for one cycle.
- Same-cycle confirm and timeout at cycle 12 → a single fire_p with auto_fire=0, followed by P_WAIT.
- Clamping:
  - ship_q=7: the PC scores 15 hits → lose=1 exactly on the 15th hit.
  - ship_q=0: a single PC hit → lose=1.
- start pulsed during P_WAIT is ignored. start in END restarts: win and lose clear, state=1.
- Reset asserted during PC_TURN → fire_pc, all other outputs and state read 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/battleship_turn_ctrl.sv
// battleship_turn_ctrl: game sequencer for the 5x5 battleship board.
// It runs player placement, then PC placement. It then alternates timed
// player shots with PC shots, and counts the ship cells left on each side
// to declare a win or a loss. Every output comes straight from a flop.
module battleship_turn_ctrl #(
    parameter int CYCLES_PER_SEC = 50_000_000,
    parameter int TURN_SECS      = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] ship_q,
    input  logic       confirm,
    input  logic       place_done_p,
    input  logic       place_done_pc,
    input  logic       shot_done,
    input  logic       shot_hit,
    input  logic       pc_shot_done,
    input  logic       pc_shot_hit,
    output logic       place_en_p,
    output logic       place_en_pc,
    output logic       fire_p,
    output logic       auto_fire,
    output logic       fire_pc,
    output logic [4:0] secs_left,
    output logic [2:0] state,
    output logic       win,
    output logic       lose
);

    localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_SEC - 1);
    localparam logic [4:0]    TURN_LOAD = 5'(TURN_SECS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLACE_P  = 3'd1,
        S_PLACE_PC = 3'd2,
        S_P_TURN   = 3'd3,
        S_P_WAIT   = 3'd4,
        S_PC_TURN  = 3'd5,
        S_PC_WAIT  = 3'd6,
        S_END      = 3'd7
    } state_e;

    // Ship cells for n ships of sizes 1..n, i.e. n(n+1)/2, with n clamped to 1..5.
    function automatic logic [3:0] cells_for(input logic [2:0] n);
        logic [3:0] cells;
        case (n)
            3'd0, 3'd1: cells = 4'd1;
            3'd2:       cells = 4'd3;
            3'd3:       cells = 4'd6;
            3'd4:       cells = 4'd10;
            default:    cells = 4'd15;
        endcase
        return cells;
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    pc_left_q, pc_left_d;
    logic [3:0]    p_left_q, p_left_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    secs_q, secs_d;
    logic          fire_p_q, fire_p_d;
    logic          auto_fire_q, auto_fire_d;
    logic          fire_pc_q, fire_pc_d;
    logic          place_en_p_q, place_en_p_d;
    logic          place_en_pc_q, place_en_pc_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;
    logic          tick_s;

    // A countdown tick happens when the prescaler wraps while the player turn runs.
    always_comb begin
        tick_s = 1'b0;
        if (state_q == S_P_TURN && presc_q == PRESC_MAX) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Compute the next state, the shot strobes, the ship counters and the result flags.
    always_comb begin
        state_d     = state_q;
        pc_left_d   = pc_left_q;
        p_left_d    = p_left_q;
        win_d       = win_q;
        lose_d      = lose_q;
        fire_p_d    = 1'b0;
        auto_fire_d = 1'b0;
        case (state_q)
            S_IDLE, S_END: begin
                if (start) begin
                    pc_left_d = cells_for(ship_q);
                    p_left_d  = cells_for(ship_q);
                    win_d     = 1'b0;
                    lose_d    = 1'b0;
                    state_d   = S_PLACE_P;
                end else begin
                    state_d = state_q;
                end
            end
            S_PLACE_P: begin
                if (place_done_p) begin
                    state_d = S_PLACE_PC;
                end else begin
                    state_d = S_PLACE_P;
                end
            end
            S_PLACE_PC: begin
                if (place_done_pc) begin
                    state_d = S_P_TURN;
                end else begin
                    state_d = S_PLACE_PC;
                end
            end
            S_P_TURN: begin
                // confirm wins over a simultaneous timeout, so auto_fire stays low.
                if (confirm) begin
                    fire_p_d = 1'b1;
                    state_d  = S_P_WAIT;
                end else if (tick_s && secs_q <= 5'd1) begin
                    fire_p_d    = 1'b1;
                    auto_fire_d = 1'b1;
                    state_d     = S_P_WAIT;
                end else begin
                    state_d = S_P_TURN;
                end
            end
            S_P_WAIT: begin
                if (shot_done) begin
                    if (shot_hit && pc_left_q != 4'd0) begin
                        pc_left_d = pc_left_q - 4'd1;
                        if (pc_left_q == 4'd1) begin
                            win_d   = 1'b1;
                            state_d = S_END;
                        end else begin
                            state_d = S_PC_TURN;
                        end
                    end else begin
                        state_d = S_PC_TURN;
                    end
                end else begin
                    state_d = S_P_WAIT;
                end
            end
            S_PC_TURN: begin
                state_d = S_PC_WAIT;
            end
            S_PC_WAIT: begin
                if (pc_shot_done) begin
                    if (pc_shot_hit && p_left_q != 4'd0) begin
                        p_left_d = p_left_q - 4'd1;
                        if (p_left_q == 4'd1) begin
                            lose_d  = 1'b1;
                            state_d = S_END;
                        end else begin
                            state_d = S_P_TURN;
                        end
                    end else begin
                        state_d = S_P_TURN;
                    end
                end else begin
                    state_d = S_PC_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Turn timer: reload on entry to P_TURN, count down on ticks, and read 0 elsewhere.
    always_comb begin
        secs_d  = 5'd0;
        presc_d = '0;
        if (state_d == S_P_TURN) begin
            if (state_q != S_P_TURN) begin
                secs_d  = TURN_LOAD;
                presc_d = '0;
            end else if (tick_s) begin
                secs_d  = secs_q - 5'd1;
                presc_d = '0;
            end else begin
                secs_d  = secs_q;
                presc_d = presc_q + PW'(1);
            end
        end else begin
            secs_d  = 5'd0;
            presc_d = '0;
        end
    end

    // Decode the level outputs from the upcoming state so they line up with the state output.
    always_comb begin
        place_en_p_d  = (state_d == S_PLACE_P);
        place_en_pc_d = (state_d == S_PLACE_PC);
        fire_pc_d     = (state_d == S_PC_TURN);
    end

    // Register the state, the counters and every output. The async reset clears them all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_left_q     <= 4'd0;
            p_left_q      <= 4'd0;
            presc_q       <= '0;
            secs_q        <= 5'd0;
            fire_p_q      <= 1'b0;
            auto_fire_q   <= 1'b0;
            fire_pc_q     <= 1'b0;
            place_en_p_q  <= 1'b0;
            place_en_pc_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_left_q     <= pc_left_d;
            p_left_q      <= p_left_d;
            presc_q       <= presc_d;
            secs_q        <= secs_d;
            fire_p_q      <= fire_p_d;
            auto_fire_q   <= auto_fire_d;
            fire_pc_q     <= fire_pc_d;
            place_en_p_q  <= place_en_p_d;
            place_en_pc_q <= place_en_pc_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    assign state       = state_q;
    assign secs_left   = secs_q;
    assign fire_p      = fire_p_q;
    assign auto_fire   = auto_fire_q;
    assign fire_pc     = fire_pc_q;
    assign place_en_p  = place_en_p_q;
    assign place_en_pc = place_en_pc_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// tb_battleship_turn_ctrl: directed scenarios followed by random games.
// Every cycle, the DUT outputs are compared against a game-level reference model.
module tb_battleship_turn_ctrl;

    localparam int CPS = 4;
    localparam int TS  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] ship_q = 3'd0;
    logic       confirm = 1'b0;
    logic       place_done_p = 1'b0;
    logic       place_done_pc = 1'b0;
    logic       shot_done = 1'b0;
    logic       shot_hit = 1'b0;
    logic       pc_shot_done = 1'b0;
    logic       pc_shot_hit = 1'b0;
    logic       place_en_p, place_en_pc, fire_p, auto_fire, fire_pc, win, lose;
    logic [4:0] secs_left;
    logic [2:0] state;

    battleship_turn_ctrl #(.CYCLES_PER_SEC(CPS), .TURN_SECS(TS)) dut (
        .clk(clk), .rst(rst), .start(start), .ship_q(ship_q), .confirm(confirm),
        .place_done_p(place_done_p), .place_done_pc(place_done_pc),
        .shot_done(shot_done), .shot_hit(shot_hit),
        .pc_shot_done(pc_shot_done), .pc_shot_hit(pc_shot_hit),
        .place_en_p(place_en_p), .place_en_pc(place_en_pc),
        .fire_p(fire_p), .auto_fire(auto_fire), .fire_pc(fire_pc),
        .secs_left(secs_left), .state(state), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int fire_pc_count = 0;

    // Reference model: game phase, cells left per side, and cycles elapsed in the player turn.
    int m_state, m_pc_left, m_p_left, m_turn_cyc;
    bit m_win, m_lose, m_fire_p, m_auto;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    endtask

    function automatic int clamp_n(input int raw);
        if (raw < 1) return 1;
        if (raw > 5) return 5;
        return raw;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pc_left = 0; m_p_left = 0; m_turn_cyc = 0;
        m_win = 0; m_lose = 0; m_fire_p = 0; m_auto = 0;
    endtask

    // Advance the model by one clock edge, using the inputs currently applied.
    task automatic model_edge();
        int n;
        m_fire_p = 0;
        m_auto = 0;
        case (m_state)
            0, 7: if (start) begin
                n = clamp_n(int'(ship_q));
                m_pc_left = n * (n + 1) / 2;
                m_p_left = m_pc_left;
                m_win = 0; m_lose = 0;
                m_state = 1;
            end
            1: if (place_done_p) m_state = 2;
            2: if (place_done_pc) begin m_state = 3; m_turn_cyc = 0; end
            3: begin
                m_turn_cyc++;
                if (confirm || m_turn_cyc == TS * CPS) begin
                    m_fire_p = 1;
                    m_auto = !confirm;
                    m_state = 4;
                end
            end
            4: if (shot_done) begin
                if (shot_hit && m_pc_left > 0) m_pc_left--;
                if (shot_hit && m_pc_left == 0) begin m_win = 1; m_state = 7; end
                else m_state = 5;
            end
            5: m_state = 6;
            6: if (pc_shot_done) begin
                if (pc_shot_hit && m_p_left > 0) m_p_left--;
                if (pc_shot_hit && m_p_left == 0) begin m_lose = 1; m_state = 7; end
                else begin m_state = 3; m_turn_cyc = 0; end
            end
            default: m_state = 0;
        endcase
    endtask

    function automatic int exp_secs();
        if (m_state == 3) return TS - m_turn_cyc / CPS;
        return 0;
    endfunction

    task automatic check_outputs();
        check_eq("state", state, m_state);
        check_eq("secs_left", secs_left, exp_secs());
        check_eq("strobes", {fire_p, auto_fire, fire_pc}, {m_fire_p, m_auto, (m_state == 5)});
        check_eq("place_en", {place_en_p, place_en_pc}, {(m_state == 1), (m_state == 2)});
        check_eq("result", {win, lose}, {m_win, m_lose});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (fire_pc) fire_pc_count++;
        check_outputs();
        start = 1'b0; confirm = 1'b0; shot_done = 1'b0; shot_hit = 1'b0;
        pc_shot_done = 1'b0; pc_shot_hit = 1'b0;
    endtask

    task automatic go_play(input int n);
        ship_q = 3'(n);
        start = 1'b1;
        tick();
        repeat ($urandom_range(0, 2)) tick();
        place_done_p = 1'b1;
        tick();
        place_done_p = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        place_done_pc = 1'b1;
        tick();
        place_done_pc = 1'b0;
    endtask

    task automatic player_turn(input int delay, input bit hit);
        repeat (delay) tick();
        confirm = 1'b1;
        tick();
        shot_done = 1'b1;
        shot_hit = hit;
        tick();
    endtask

    task automatic pc_turn(input bit hit);
        tick();
        pc_shot_done = 1'b1;
        pc_shot_hit = hit;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Normal game with ship_q=2: three player hits win, with two PC turns in between.
        go_play(2);
        fire_pc_count = 0;
        player_turn(2, 1'b1);
        pc_turn(1'b0);
        confirm = 1'b1;
        tick();
        start = 1'b1;
        confirm = 1'b1;
        tick();
        check_eq("start_in_pwait", state, 3'd4);
        shot_done = 1'b1; shot_hit = 1'b1;
        tick();
        pc_turn(1'b0);
        player_turn(5, 1'b1);
        check_eq("win_flag", {win, lose, state}, {1'b1, 1'b0, 3'd7});
        check_eq("fire_pc_count", fire_pc_count, 2);

        // A start in END restarts the game, then the player turn runs out.
        ship_q = 3'd3;
        start = 1'b1;
        tick();
        check_eq("restart", {win, lose, state}, {1'b0, 1'b0, 3'd1});
        place_done_p = 1'b1; tick(); place_done_p = 1'b0;
        place_done_pc = 1'b1; tick(); place_done_pc = 1'b0;
        repeat (11) tick();
        check_eq("pre_timeout", {fire_p, secs_left}, {1'b0, 5'd1});
        tick();
        check_eq("timeout_strobe", {fire_p, auto_fire, secs_left}, {1'b1, 1'b1, 5'd0});
        shot_done = 1'b1;
        tick();
        pc_turn(1'b0);

        // confirm arrives on the same edge as the timeout.
        repeat (11) tick();
        confirm = 1'b1;
        tick();
        check_eq("same_cycle", {fire_p, auto_fire, state}, {1'b1, 1'b0, 3'd4});
        tick();
        check_eq("single_shot", fire_p, 1'b0);
        shot_done = 1'b1;
        tick();

        // Reset while in PC_TURN clears everything without waiting for a clock edge.
        check_eq("in_pc_turn", {state, fire_pc}, {3'd5, 1'b1});
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #2;
        rst = 1'b0;

        // ship_q=7 clamps to 5 ships (15 cells).
        go_play(7);
        for (int i = 0; i < 15; i++) begin
            player_turn(1, 1'b0);
            pc_turn(1'b1);
            if (i == 13) check_eq("clamp7_not_yet", lose, 1'b0);
        end
        check_eq("clamp7_lose", {lose, state}, {1'b1, 3'd7});

        // ship_q=0 clamps to 1 ship (1 cell).
        go_play(0);
        player_turn(0, 1'b0);
        pc_turn(1'b1);
        check_eq("clamp0_lose", {lose, state}, {1'b1, 3'd7});

        // Random games, with stray pulses injected in every state.
        for (int g = 0; g < 10; g++) begin
            go_play($urandom_range(0, 7));
            for (int c = 0; c < 3000 && m_state != 7; c++) begin
                case (m_state)
                    3: confirm = ($urandom_range(0, 5) == 0);
                    4: if ($urandom_range(0, 1) == 1) begin
                        shot_done = 1'b1;
                        shot_hit = ($urandom_range(0, 3) != 0);
                    end
                    6: if ($urandom_range(0, 1) == 1) begin
                        pc_shot_done = 1'b1;
                        pc_shot_hit = 1'($urandom_range(0, 1));
                    end
                    default: ;
                endcase
                if ($urandom_range(0, 39) == 0) start = 1'b1;
                if ($urandom_range(0, 19) == 0) confirm = 1'b1;
                if ($urandom_range(0, 19) == 0) begin
                    shot_done = 1'b1;
                    shot_hit = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 19) == 0) begin
                    pc_shot_done = 1'b1;
                    pc_shot_hit = 1'($urandom_range(0, 1));
                end
                tick();
            end
            check_eq("game_end", state, 3'd7);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
